// File: rtl/io_pkg.sv
// Shared definitions for slow output-pin drivers: FSM state encoding and pad polarity helper.
package io_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ON   = ST_ON,
    S_OFF  = ST_OFF
  } io_state_e;

  // Converts a logical "active" request into the physical pad level.
  function automatic logic drive_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/output_pulse_stretch_if.sv
// Event/status bundle between control logic (master) and the pulse stretcher (slave).
interface output_pulse_stretch_if #(
  parameter int QUEUE_W = 4
);
  logic               trig;
  logic               hold;
  logic               out_pin;
  logic               busy;
  logic [QUEUE_W-1:0] pending;
  logic               overflow;

  modport master (
    output trig, hold,
    input  out_pin, busy, pending, overflow
  );

  modport slave (
    input  trig, hold,
    output out_pin, busy, pending, overflow
  );
endinterface

// File: rtl/io_interval_timer.sv
// Interval counter: clears on load, counts while enabled and sticks at the terminal value.
module io_interval_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != term)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/output_pulse_stretch.sv
// Stretches 1-cycle event strobes into pulses with guaranteed ON/OFF widths on a slow pad,
// queueing events that arrive while busy and honouring a level hold request.
module output_pulse_stretch
  import io_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int ON_CYCLES  = 50000,
  parameter int OFF_CYCLES = 50000,
  parameter int QUEUE_W    = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output_pulse_stretch_if.slave  bus
);

  localparam logic [CNT_W-1:0]   ON_TERM  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OFF_TERM = CNT_W'(OFF_CYCLES - 1);
  localparam logic [QUEUE_W-1:0] Q_MAX    = '1;
  localparam logic               POL_LOW  = (ACTIVE_LOW != 0);

  io_state_e          state, state_next;
  logic [QUEUE_W-1:0] pending_q, pending_next;
  logic               overflow_q, overflow_next;
  logic               out_pin_q, busy_q;
  logic               evt, enter_on, load, tc;
  logic               trig_kept, consume_q;
  logic [CNT_W-1:0]   term;

  assign evt  = bus.trig | (pending_q != '0) | bus.hold;
  assign term = (state == S_ON) ? ON_TERM : OFF_TERM;

  io_interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (reset),
    .load (load),
    .en   (state != S_IDLE),
    .term (term),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hold at terminal keeps ON with the timer parked; OFF chains straight into the next pulse.
  always_comb begin
    state_next = state;
    enter_on   = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (evt) begin
          state_next = S_ON;
          enter_on   = 1'b1;
          load       = 1'b1;
        end
      end
      S_ON: begin
        if (tc && !bus.hold) begin
          state_next = S_OFF;
          load       = 1'b1;
        end
      end
      S_OFF: begin
        if (tc) begin
          load = 1'b1;
          if (evt) begin
            state_next = S_ON;
            enter_on   = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // A starting pulse takes this cycle's trig first; only otherwise does it draw on the queue.
  always_comb begin
    trig_kept     = bus.trig & ~enter_on;
    consume_q     = enter_on & ~bus.trig & (pending_q != '0);
    pending_next  = pending_q;
    overflow_next = 1'b0;
    if (trig_kept) begin
      if (pending_q == Q_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending_q + QUEUE_W'(1);
      end
    end else if (consume_q) begin
      pending_next = pending_q - QUEUE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      out_pin_q  <= drive_level(1'b0, POL_LOW);
      busy_q     <= 1'b0;
    end else begin
      pending_q  <= pending_next;
      overflow_q <= overflow_next;
      out_pin_q  <= drive_level(state_next == S_ON, POL_LOW);
      busy_q     <= (state_next != S_IDLE);
    end
  end

  assign bus.out_pin  = out_pin_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_output_pulse_stretch.sv
// Bench for output_pulse_stretch with ON=4, OFF=3, QUEUE_W=2, active-low pad.
module tb_output_pulse_stretch;

  localparam int QW = 2;

  typedef struct packed {
    logic          out_pin;
    logic          busy;
    logic [QW-1:0] pending;
    logic          overflow;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  obs_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  output_pulse_stretch_if #(.QUEUE_W(QW)) ifc ();

  output_pulse_stretch #(
    .CNT_W      (16),
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .QUEUE_W    (QW),
    .ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  function automatic bit inr(input int k, input int a, input int b);
    return (k >= a) && (k <= b);
  endfunction

  function automatic obs_t mk(input bit out_pin, input bit busy, input int pend, input bit ovf);
    obs_t o;
    o.out_pin  = out_pin;
    o.busy     = busy;
    o.pending  = QW'(pend);
    o.overflow = ovf;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.out_pin  = ifc.out_pin;
    o.busy     = ifc.busy;
    o.pending  = ifc.pending;
    o.overflow = ifc.overflow;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int c = 0; c <= 9; c++) begin
      reset = (c <= 2); ifc.trig = (c == 1); ifc.hold = 1'b0;
      sb.push_back(mk(1'b1, 1'b0, 0, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                 c + 1, got.out_pin, got.busy, got.pending, got.overflow, exp.out_pin, exp.busy, exp.pending, exp.overflow);
      end
    end
  endtask

  task automatic test_single();
    obs_t got, exp;
    int k;
    for (int c = 0; c <= 22; c++) begin
      k = c + 1;
      reset = (c <= 2); ifc.trig = (c == 10); ifc.hold = 1'b0;
      sb.push_back(mk(!inr(k, 11, 14), inr(k, 11, 17), 0, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single cyc %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                 k, got.out_pin, got.busy, got.pending, got.overflow, exp.out_pin, exp.busy, exp.pending, exp.overflow);
      end
    end
  endtask

  task automatic test_queue();
    obs_t got, exp;
    int k, p;
    for (int c = 0; c <= 34; c++) begin
      k = c + 1;
      reset = (c <= 2); ifc.trig = inr(c, 10, 12); ifc.hold = 1'b0;
      p = (k == 12) ? 1 : inr(k, 13, 17) ? 2 : inr(k, 18, 24) ? 1 : 0;
      sb.push_back(mk(!(inr(k, 11, 14) || inr(k, 18, 21) || inr(k, 25, 28)), inr(k, 11, 31), p, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL queue cyc %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                 k, got.out_pin, got.busy, got.pending, got.overflow, exp.out_pin, exp.busy, exp.pending, exp.overflow);
      end
    end
  endtask

  task automatic test_overflow();
    obs_t got, exp;
    int k, p;
    for (int c = 0; c <= 41; c++) begin
      k = c + 1;
      reset = (c <= 2); ifc.trig = inr(c, 10, 14); ifc.hold = 1'b0;
      p = (k == 12) ? 1 : (k == 13) ? 2 : inr(k, 14, 17) ? 3 : inr(k, 18, 24) ? 2 : inr(k, 25, 31) ? 1 : 0;
      sb.push_back(mk(!(inr(k, 11, 14) || inr(k, 18, 21) || inr(k, 25, 28) || inr(k, 32, 35)),
                      inr(k, 11, 38), p, k == 15));
      tick();
      got = sample(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL overflow cyc %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                 k, got.out_pin, got.busy, got.pending, got.overflow, exp.out_pin, exp.busy, exp.pending, exp.overflow);
      end
    end
  endtask

  task automatic test_hold();
    obs_t got, exp;
    int k;
    for (int c = 0; c <= 37; c++) begin
      k = c + 1;
      reset = (c <= 2); ifc.trig = 1'b0; ifc.hold = inr(c, 10, 30);
      sb.push_back(mk(!inr(k, 11, 31), inr(k, 11, 34), 0, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold cyc %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                 k, got.out_pin, got.busy, got.pending, got.overflow, exp.out_pin, exp.busy, exp.pending, exp.overflow);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    int k, p;
    for (int c = 0; c <= 30; c++) begin
      k = c + 1;
      reset = (c <= 2) || (c == 13); ifc.trig = inr(c, 10, 12); ifc.hold = 1'b0;
      p = (k == 12) ? 1 : (k == 13) ? 2 : 0;
      sb.push_back(mk(!inr(k, 11, 13), inr(k, 11, 13), p, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                 k, got.out_pin, got.busy, got.pending, got.overflow, exp.out_pin, exp.busy, exp.pending, exp.overflow);
      end
    end
  endtask

  // Second trig lands exactly on the last OFF cycle: next pulse must start with no idle gap.
  task automatic test_back_to_back();
    obs_t got, exp;
    int k;
    for (int c = 0; c <= 27; c++) begin
      k = c + 1;
      reset = (c <= 2); ifc.trig = (c == 10) || (c == 17); ifc.hold = 1'b0;
      sb.push_back(mk(!(inr(k, 11, 14) || inr(k, 18, 21)), inr(k, 11, 24), 0, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                 k, got.out_pin, got.busy, got.pending, got.overflow, exp.out_pin, exp.busy, exp.pending, exp.overflow);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    ifc.trig = 1'b0;
    ifc.hold = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
